// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU front end.
// Latency: none, constants and types only.
// Backpressure: not applicable.
package cpu_pkg;

  localparam int INSTR_W = 16;

  // Instruction field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;
  localparam int IMM_MSB = 9;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_MSB-OPC_LSB:0] OPCODE_HALT = 6'b111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register: reset load, wrapping increment, branch load.
// Latency: new value visible one clk after inc/load.
// Backpressure: holds value whenever neither inc nor load is asserted.
module program_counter #(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_val,
  output logic [PC_WIDTH-1:0] pc
);

  // Branch load wins over increment; increment wraps naturally at 2^PC_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, memory req/ack handshake, instruction register and field split.
// Latency: instr_valid rises the cycle after the mem_ack cycle.
// Backpressure: stall holds the issued instruction, PC and outputs frozen.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH    = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]          OPCODE_HALT = cpu_pkg::OPCODE_HALT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        mem_req,
  output logic [PC_WIDTH-1:0]         mem_addr,
  input  logic                        mem_ack,
  input  logic [cpu_pkg::INSTR_W-1:0] mem_rdata,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [PC_WIDTH-1:0]         branch_target,
  output logic                        instr_valid,
  output logic [cpu_pkg::INSTR_W-1:0] instr,
  output logic [5:0]                  opcode,
  output logic [9:0]                  imm10,
  output logic [PC_WIDTH-1:0]         pc_out,
  output logic                        halt
);

  import cpu_pkg::*;

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_inc;
  logic                pc_load;

  // PC advances when a fetch completes and reloads on an unstalled branch
  assign pc_inc  = (state == S_FETCH) && mem_ack;
  assign pc_load = (state == S_ISSUE) && !stall && branch_taken;

  program_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (branch_target),
    .pc       (pc)
  );

  // Address always reflects the PC register, so it is stable for the whole fetch
  assign mem_addr = pc;
  assign opcode   = instr[OPC_MSB:OPC_LSB];
  assign imm10    = instr[IMM_MSB:IMM_LSB];

  // Fetch FSM with the instruction register and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instr       <= '0;
      pc_out      <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      halt        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
        end
        S_FETCH: begin
          if (mem_ack) begin
            instr       <= mem_rdata;
            pc_out      <= pc;
            state       <= S_ISSUE;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            // A taken branch overrides a HALT opcode in the same slot
            if (branch_taken || (opcode != OPCODE_HALT)) begin
              state   <= S_FETCH;
              mem_req <= 1'b1;
            end else begin
              state <= S_HALT;
              halt  <= 1'b1;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state       <= S_IDLE;
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
          halt        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the 16-bit CPU. It holds the program counter and runs a request/acknowledge handshake with instruction memory. It latches each returned word into an instruction register and splits it into a 6-bit opcode and a 10-bit immediate. The immediate output feeds the 10-to-16-bit sign-extension stage directly downstream; the opcode goes to the control decoder.

Parameters:
PC_WIDTH, 10, width of program counter and memory address
RESET_PC, 0, PC value loaded on reset
OPCODE_HALT, 6'b111111, opcode that stops fetching

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset; one clock clk; reset rst_n asynchronous, active-low
mem_req  output  1  fetch request to instruction memory
mem_addr  output  PC_WIDTH  fetch address (current PC)
mem_ack  input  1  memory has valid data on mem_rdata this cycle
mem_rdata  input  16  instruction word from memory
stall  input  1  downstream not ready; hold current instruction
branch_taken  input  1  redirect PC; sampled only on issue handshake
branch_target  input  PC_WIDTH  new PC when branch_taken
instr_valid  output  1  instr/opcode/imm10/pc_out are valid
instr  output  16  latched instruction register
opcode  output  6  instr[15:10]
imm10  output  10  instr[9:0], to sign-extension stage
pc_out  output  PC_WIDTH  address the current instruction was fetched from
halt  output  1  HALT opcode reached; fetching stopped

Behaviour:
- States: S_IDLE, S_FETCH, S_ISSUE, S_HALT. The async reset forces S_IDLE.
- Reset values:
  - pc = RESET_PC, mem_addr = RESET_PC.
  - instr = 0, opcode = 0, imm10 = 0, pc_out = 0.
  - mem_req = 0, instr_valid = 0, halt = 0.
- S_IDLE:
  - All outputs inactive.
  - Unconditionally go to S_FETCH on the first rising edge after rst_n deasserts.
- S_FETCH:
  - mem_req = 1, mem_addr = pc. Wait any number of cycles for mem_ack.
  - On a mem_ack edge:
    - instr <= mem_rdata and pc_out <= pc.
    - pc <= pc + 1, modulo 2^PC_WIDTH; max wraps to 0.
    - Go to S_ISSUE.
  - mem_rdata is ignored when mem_ack = 0.
- S_ISSUE:
  - instr_valid = 1, mem_req = 0.
  - Latency: instr_valid rises the cycle after the mem_ack cycle.
  - stall = 1: hold every output and pc unchanged. branch_taken is ignored while stall = 1.
  - stall = 0 and branch_taken = 1: pc <= branch_target, go to S_FETCH. Branch takes priority over HALT.
  - stall = 0 and opcode == OPCODE_HALT: go to S_HALT.
  - Otherwise: go to S_FETCH.
- S_HALT:
  - halt = 1, instr_valid = 0, mem_req = 0.
  - instr keeps the HALT word.
  - Only rst_n exits this state.
- mem_ack outside S_FETCH is ignored; no state change.
- Reset mid-operation (including during a pending fetch): all state clears immediately, mem_req drops asynchronously, and any in-flight memory response is discarded.
- opcode and imm10 are pure slices of the instr register; they add no extra register stage.
- Outputs decode from state and the registers only; no combinational path from any input to any output.

Decomposition:
- Shared package cpu_pkg holds:
  - OPCODE_HALT and opcode field positions (OPC_MSB=15, OPC_LSB=10, IMM_MSB=9, IMM_LSB=0).
  - The fetch state encoding (2-bit enum).
  - The instruction width constant (16).
- One sub-module, program_counter: PC register with reset load, increment-with-wrap, and branch load.
- The FSM and instruction register live in instr_fetch_unit.

Test Plan:
1. Reset then fetch: release rst_n, memory acks addr 0 after 2 wait cycles with 16'h0C05 -> mem_req high 3 cycles, then instr_valid = 1, opcode = 6'h03, imm10 = 10'h005, pc_out = 0, mem_addr next fetch = 1.
2. Stall hold: in S_ISSUE hold stall = 1 for 4 cycles with branch_taken = 1 -> outputs frozen, no mem_req, branch ignored; stall = 0 with branch_taken = 0 -> next fetch from pc + 1.
3. Branch: issue instr at pc 5 with stall = 0, branch_taken = 1, branch_target = 10'h3F0 -> next mem_addr = 10'h3F0, pc_out of following instruction = 10'h3F0.
4. Wrap-around: fetch at pc 10'h3FF -> following mem_addr = 10'h000.
5. Halt: memory returns 16'hFC00 -> instr_valid one cycle, then halt = 1, mem_req stays 0 for 20 cycles despite mem_ack pulses.
6. Async reset mid-fetch: assert rst_n = 0 between clock edges while mem_req = 1 -> mem_req, instr_valid, halt and instr all 0 before the next edge; restart fetches from RESET_PC.
